// File: rtl/ibex_fetch_align_fifo.sv
// Fetch word FIFO with halfword realignment for mixed 16/32-bit (RVC) instructions.
// Presents one whole instruction per cycle with its PC, straight from the head entries.
module ibex_fetch_align_fifo #(
  parameter int unsigned DEPTH     = 3,
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0080
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clear_i,
  input  logic [31:0] clear_pc_i,
  input  logic        in_valid_i,
  input  logic [31:0] in_rdata_i,
  output logic        in_ready_o,
  output logic        out_valid_o,
  output logic [31:0] out_rdata_o,
  output logic [31:0] out_pc_o,
  output logic        out_compressed_o,
  input  logic        out_ready_i
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  logic [31:0] mem [DEPTH];
  ptr_t        rptr, wptr;
  cnt_t        count;
  logic [31:0] pc;

  // Pointers wrap explicitly so non-power-of-2 depths work.
  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
  endfunction

  logic [31:0] w0, w1;
  logic [15:0] half;
  logic        empty, is_comp, need_two;
  logic        push, fire, pop;

  assign w0       = mem[rptr];
  assign w1       = mem[ptr_inc(rptr)];
  assign half     = pc[1] ? w0[31:16] : w0[15:0];
  assign is_comp  = (half[1:0] != 2'b11);
  // An uncompressed instruction at an odd halfword straddles two words.
  assign need_two = pc[1] & ~is_comp;
  assign empty    = (count == '0);

  assign in_ready_o  = (count < cnt_t'(DEPTH));
  assign out_valid_o = need_two ? (count >= cnt_t'(2)) : ~empty;
  assign out_pc_o    = pc;

  always_comb begin
    out_rdata_o      = '0;
    out_compressed_o = 1'b0;
    if (!empty) begin
      out_compressed_o = is_comp;
      if (is_comp)    out_rdata_o = {16'h0, half};
      else if (pc[1]) out_rdata_o = {w1[15:0], w0[31:16]};
      else            out_rdata_o = w0;
    end
  end

  assign push = in_valid_i & in_ready_o & ~clear_i;
  assign fire = out_valid_o & out_ready_i & ~clear_i;
  // Only a low-half compressed instruction leaves the head word in place.
  assign pop  = fire & (pc[1] | ~is_comp);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
      pc    <= {BOOT_ADDR[31:1], 1'b0};
    end else if (clear_i) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
      pc    <= {clear_pc_i[31:1], 1'b0};
    end else begin
      if (push) wptr <= ptr_inc(wptr);
      if (pop)  rptr <= ptr_inc(rptr);
      case ({push, pop})
        2'b10:   count <= count + cnt_t'(1);
        2'b01:   count <= count - cnt_t'(1);
        default: count <= count;
      endcase
      if (fire) pc <= pc + (is_comp ? 32'd2 : 32'd4);
    end
  end

  // Storage needs no reset; count gates every read.
  always_ff @(posedge clk_i) begin
    if (push) mem[wptr] <= in_rdata_i;
  end

endmodule

// File: tb/tb_ibex_fetch_align_fifo.sv
// Directed bench for ibex_fetch_align_fifo: expected instructions are queued when words
// are driven and compared whenever the DUT completes a handshake.
module tb_ibex_fetch_align_fifo;
  localparam int unsigned DEPTH = 3;

  logic        clk = 1'b0;
  logic        rst_n, clear, in_valid, in_ready, out_valid, out_comp, out_ready;
  logic [31:0] clear_pc, in_rdata, out_rdata, out_pc;

  typedef struct {
    logic [31:0] d;
    logic [31:0] pc;
    logic        c;
  } exp_t;
  exp_t sb[$];

  int passed = 0;
  int total  = 0;

  ibex_fetch_align_fifo #(.DEPTH(DEPTH), .BOOT_ADDR(32'h0000_0081)) dut (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .clear_pc_i(clear_pc),
    .in_valid_i(in_valid), .in_rdata_i(in_rdata), .in_ready_o(in_ready),
    .out_valid_o(out_valid), .out_rdata_o(out_rdata), .out_pc_o(out_pc),
    .out_compressed_o(out_comp), .out_ready_i(out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic expect_instr(input logic [31:0] d, input logic [31:0] pc, input logic c);
    exp_t e;
    e.d = d; e.pc = pc; e.c = c;
    sb.push_back(e);
  endtask

  // Settle, score any handshake completing this cycle, then advance one clock.
  task automatic tick();
    exp_t e;
    #1;
    if (rst_n && out_valid && out_ready && !clear) begin
      if (sb.size() == 0) begin
        chk("unexpected_fire", out_pc, 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        chk("fire_rdata", out_rdata, e.d);
        chk("fire_pc", out_pc, e.pc);
        chk("fire_comp", {31'h0, out_comp}, {31'h0, e.c});
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [31:0] w);
    in_valid = 1'b1;
    in_rdata = w;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; clear_pc = '0; in_valid = 1'b0; in_rdata = '0; out_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    chk("rst_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_ready", {31'h0, in_ready}, 32'h1);
    chk("rst_pc", out_pc, 32'h80);
    chk("rst_rdata", out_rdata, 32'h0);

    // Aligned uncompressed
    out_ready = 1'b1;
    expect_instr(32'h0000_0513, 32'h80, 1'b0);
    push_word(32'h0000_0513);
    chk("t1_valid", {31'h0, out_valid}, 32'h1);
    tick();
    chk("t1_pc_after", out_pc, 32'h84);
    chk("t1_empty", {31'h0, out_valid}, 32'h0);

    // Two compressed in one word
    expect_instr(32'h0000_4501, 32'h84, 1'b1);
    expect_instr(32'h0000_4505, 32'h86, 1'b1);
    push_word(32'h4505_4501);
    tick();
    chk("t2_mid_pc", out_pc, 32'h86);
    chk("t2_mid_valid", {31'h0, out_valid}, 32'h1);
    tick();
    chk("t2_pc_after", out_pc, 32'h88);
    chk("t2_empty", {31'h0, out_valid}, 32'h0);

    // Compressed, then uncompressed straddling two words
    expect_instr(32'h0000_4501, 32'h88, 1'b1);
    expect_instr(32'h0000_0513, 32'h8A, 1'b0);
    push_word(32'h0513_4501);
    tick();
    chk("t3_wait_valid", {31'h0, out_valid}, 32'h0);
    tick();
    chk("t3_wait_valid2", {31'h0, out_valid}, 32'h0);
    chk("t3_wait_pc", out_pc, 32'h8A);
    push_word(32'h1111_0000);
    chk("t3_straddle_valid", {31'h0, out_valid}, 32'h1);
    expect_instr(32'h0000_1111, 32'h8E, 1'b1);
    tick();
    chk("t3_tail_pc", out_pc, 32'h8E);
    tick();
    chk("t3_pc_after", out_pc, 32'h90);
    chk("t3_empty", {31'h0, out_valid}, 32'h0);

    // Fill to DEPTH with consumer stalled, then drain
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      push_word(32'hA000_0003 | (i << 8));
      chk("t4_in_ready", {31'h0, in_ready}, (i < DEPTH - 1) ? 32'h1 : 32'h0);
    end
    push_word(32'hDEAD_BEEF);
    chk("t4_full_ready", {31'h0, in_ready}, 32'h0);
    for (int i = 0; i < DEPTH; i++)
      expect_instr(32'hA000_0003 | (i << 8), 32'h90 + 4 * i, 1'b0);
    out_ready = 1'b1;
    #1;
    chk("t4_no_comb_ready", {31'h0, in_ready}, 32'h0);
    tick();
    chk("t4_ready_after_pop", {31'h0, in_ready}, 32'h1);
    for (int i = 1; i < DEPTH; i++) tick();
    chk("t4_drained", {31'h0, out_valid}, 32'h0);
    chk("t4_pc_after", out_pc, 32'h90 + 4 * DEPTH);

    // Clear with two words buffered and a word presented in the clear cycle
    out_ready = 1'b0;
    push_word(32'h0000_0013);
    push_word(32'h0000_0093);
    clear = 1'b1; clear_pc = 32'h0000_1003; in_valid = 1'b1; in_rdata = 32'hCAFE_0001;
    tick();
    clear = 1'b0; in_valid = 1'b0;
    chk("t5_valid", {31'h0, out_valid}, 32'h0);
    chk("t5_pc", out_pc, 32'h1002);
    chk("t5_ready", {31'h0, in_ready}, 32'h1);
    out_ready = 1'b1;
    expect_instr(32'h0000_4505, 32'h1002, 1'b1);
    push_word(32'h4505_0001);
    tick();
    chk("t5_pc_after", out_pc, 32'h1004);
    chk("t5_empty", {31'h0, out_valid}, 32'h0);

    // PC wraps modulo 2^32
    clear = 1'b1; clear_pc = 32'hFFFF_FFFE;
    tick();
    clear = 1'b0;
    expect_instr(32'h0000_4501, 32'hFFFF_FFFE, 1'b1);
    push_word(32'h4501_0000);
    tick();
    chk("t6_wrap_pc", out_pc, 32'h0);

    // Reset while full
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) push_word(32'h0000_0513);
    chk("t7_full", {31'h0, in_ready}, 32'h0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("t7_valid", {31'h0, out_valid}, 32'h0);
    chk("t7_ready", {31'h0, in_ready}, 32'h1);
    chk("t7_pc", out_pc, 32'h80);

    chk("sb_empty", sb.size(), 32'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/ibex_fetch_align_fifo.md
Name: ibex_fetch_align_fifo

Overview:
Instruction fetch buffer that sits directly upstream of the branch predictor in the IF stage. It accepts sequential 32-bit fetch words from the instruction memory interface and stores them in a small FIFO. It realigns 16/32-bit (RVC) instructions at halfword granularity and presents one whole instruction per cycle, with its PC. Its outputs drive the predictor's fetch_rdata/fetch_pc/fetch_valid; clear_i (branch/jump/predicted-taken redirect) flushes it and reloads the PC.

Parameters:
DEPTH, 3, number of 32-bit word entries (>=2).
BOOT_ADDR, 32'h0000_0080, PC after reset (bit 0 ignored).

Ports:
clk_i  in  1  clock, all state updates on rising edge
rst_ni  in  1  synchronous active-low reset
clear_i  in  1  flush all entries; load PC from clear_pc_i
clear_pc_i  in  32  new PC on clear (bit 0 forced 0)
in_valid_i  in  1  fetch word valid
in_rdata_i  in  32  fetch word (the word containing the current fetch address, then sequential words)
in_ready_o  out  1  FIFO can accept a word this cycle
out_valid_o  out  1  whole instruction available
out_rdata_o  out  32  instruction; compressed ones zero-extended to 32 bits
out_pc_o  out  32  PC of out_rdata_o
out_compressed_o  out  1  out_rdata_o is a 16-bit instruction
out_ready_i  in  1  consumer accepts the instruction

Behaviour:
- Reset (rst_ni=0 at clock edge) produces: count=0, pc=BOOT_ADDR with bit 0 cleared, out_valid_o=0, in_ready_o=1 in the following cycle. Data outputs read 0 while empty.
- in_ready_o = (count < DEPTH); registered-state only, with no combinational path from out_ready_i.
- Push when in_valid_i & in_ready_o & ~clear_i. Word appended at tail.
- Head word W0, next word W1. pc[1] selects the halfword.
- pc[1]=0, W0[1:0]!=2'b11: compressed; out_rdata_o={16'h0,W0[15:0]}; valid when count>=1.
- pc[1]=0, W0[1:0]==2'b11: out_rdata_o=W0; valid when count>=1.
- pc[1]=1, W0[17:16]!=2'b11: compressed; out_rdata_o={16'h0,W0[31:16]}; valid when count>=1.
- pc[1]=1, W0[17:16]==2'b11: out_rdata_o={W1[15:0],W0[31:16]}; valid only when count>=2.
- out_pc_o = pc; out_compressed_o = (selected low halfword [1:0] != 2'b11).
- Data outputs are combinational from FIFO head and pc (zero added latency). Word pushed in cycle N is visible in cycle N+1.
- Handshake: fire = out_valid_o & out_ready_i & ~clear_i. On fire, pc += 2 (compressed) or 4. Wrap-around is modulo 2^32.
- Pop head word on fire when the instruction ends at or crosses the word boundary:
  - pc[1]=0 uncompressed: pop.
  - pc[1]=1 (either size): pop.
  - pc[1]=0 compressed: no pop.
  - At most one pop per cycle.
- Simultaneous push and pop keeps count unchanged. Push when full is impossible because in_ready_o=0.
- clear_i has priority over push and fire:
  - next cycle count=0 and pc={clear_pc_i[31:1],1'b0};
  - any word presented in the clear cycle is discarded;
  - out_valid_o=0 the following cycle.
- clear_i during reset: reset wins.
- Fetch words are assumed sequential. Address checking belongs to the fetch requester.
- Storage: circular buffer with log2 read/write pointers and a count. Pointers wrap at DEPTH, including non-power-of-2 values.

Test Plan:
- Reset, then push 32'h0000_0513 (addi), out_ready_i=1 -> next cycle out_valid_o=1, out_pc_o=32'h80, out_rdata_o=32'h0000_0513, out_compressed_o=0; after fire count=0, pc=32'h84.
- Push 32'h4505_4501 (two c.li) -> first cycle out_rdata_o=32'h0000_4501, pc=32'h80, no pop. Next cycle out_rdata_o=32'h0000_4505, pc=32'h82, pop. Final pc=32'h84.
- Push 32'h0513_4501 then 32'h1111_0000 -> compressed 32'h4501 at 32'h80. Then the misaligned uncompressed instruction at 32'h82 stays out_valid_o=0 until the second word arrives. It then emits out_rdata_o=32'h0000_0513 with out_pc_o=32'h82; pc becomes 32'h86 and the first word is popped.
- Hold out_ready_i=0 and push DEPTH words -> in_ready_o=0 after the DEPTH-th push, no overwrite. Release -> words drain in order, and in_ready_o rises in the cycle after the first pop.
- With 2 words buffered, assert clear_i with clear_pc_i=32'h0000_1003 and in_valid_i=1 -> next cycle out_valid_o=0, pc=32'h1002, the word from the clear cycle is discarded. The next pushed word yields an instruction at 32'h1002 from bits [31:16].
- Assert rst_ni=0 mid-stream while full -> next cycle out_valid_o=0, in_ready_o=1, out_pc_o=32'h80.
